// File: rtl/vm_disp_pkg.sv
// Shared display-path types and constants: scan state, segment/anode idle codes, BCD segment table.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package vm_disp_pkg;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_TENS = 2'd1,
    S_HUND = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [2:0] AN_OFF   = 3'b111;

  // Codes 10..15 are not BCD and render as a dash.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Digit-load and display-pin bundle between the BCD converter, the scanner and the board.
interface bcd_seg_scan_if;
  logic       load;
  logic [3:0] h;
  logic [3:0] t;
  logic [3:0] o;
  logic       blank;
  logic [6:0] seg;
  logic [2:0] an;
  logic       slot_done;

  modport master (
    output load, h, t, o, blank,
    input  seg, an, slot_done
  );

  modport slave (
    input  load, h, t, o, blank,
    output seg, an, slot_done
  );
endinterface

// File: rtl/bcd_seg_enc.sv
// Combinational 4-bit code to active-low seven-segment pattern.
module bcd_seg_enc
  import vm_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/bcd_seg_scan.sv
// Three-digit common-anode scanner with per-slot dead time and registered pin outputs.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading-zero hundreds/tens digits.
module bcd_seg_scan
  import vm_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEAD_CYC = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_seg_scan_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CntDead = CNT_W'(DEAD_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  scan_state_e      state_q, state_d;
  logic [3:0]       h_q, h_d, t_q, t_d, o_q, o_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;
  logic             slot_done_q, slot_done_d;

  logic             cnt_last;
  logic [3:0]       digit_sel;
  logic [2:0]       an_sel;
  logic             digit_on;
  logic [6:0]       seg_enc;

  bcd_seg_enc u_enc (
    .digit_i (digit_sel),
    .seg_o   (seg_enc)
  );

  always_comb begin
    cnt_last = (cnt_q == CntLast);
    cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;

    state_d = state_q;
    case (state_q)
      S_ONES:  if (cnt_last) state_d = S_TENS;
      S_TENS:  if (cnt_last) state_d = S_HUND;
      S_HUND:  if (cnt_last) state_d = S_ONES;
      default: state_d = S_ONES;
    endcase

    h_d = bus.load ? bus.h : h_q;
    t_d = bus.load ? bus.t : t_q;
    o_d = bus.load ? bus.o : o_q;

    digit_on = 1'b1;
    case (state_q)
      S_TENS: begin
        digit_sel = t_q;
        an_sel    = 3'b101;
      end
      S_HUND: begin
        digit_sel = h_q;
        an_sel    = 3'b011;
      end
      default: begin
        digit_sel = o_q;
        an_sel    = 3'b110;
      end
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    if (state_q == S_HUND && h_q == 4'd0) digit_on = 1'b0;
    if (state_q == S_TENS && h_q == 4'd0 && t_q == 4'd0) digit_on = 1'b0;
`endif

    if (bus.blank || (cnt_q < CntDead) || !digit_on) begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end else begin
      seg_d = seg_enc;
      an_d  = an_sel;
    end

    slot_done_d = (state_q == S_HUND) && cnt_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      state_q     <= S_ONES;
      h_q         <= '0;
      t_q         <= '0;
      o_q         <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      slot_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      h_q         <= h_d;
      t_q         <= t_d;
      o_q         <= o_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      slot_done_q <= slot_done_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.slot_done = slot_done_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan with SCAN_DIV=4, DEAD_CYC=1: directed plan steps plus random load/blank
// traffic, predicted from elapsed cycle count and latched digits.
module tb_bcd_seg_scan;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_seg_scan_if bus ();

  bcd_seg_scan #(
    .SCAN_DIV (4),
    .DEAD_CYC (1),
    .CNT_W    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int unsigned m_n;
  logic [3:0]  m_h, m_t, m_o;

  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict from the pre-edge cycle index, then compare after the edge.
  task automatic step(input logic ld, input logic [3:0] hh, input logic [3:0] tt,
                      input logic [3:0] oo, input logic bl);
    int unsigned pos, slot;
    logic        lit;
    logic [3:0]  digit;
    logic [6:0]  es;
    logic [2:0]  ea;
    logic        ed;
    bus.load  = ld;
    bus.h     = hh;
    bus.t     = tt;
    bus.o     = oo;
    bus.blank = bl;
    pos  = m_n % 4;
    slot = (m_n / 4) % 3;
    lit  = !bl && (pos >= 1);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 2 && m_h == 4'd0) lit = 1'b0;
    if (slot == 1 && m_h == 4'd0 && m_t == 4'd0) lit = 1'b0;
`endif
    digit = (slot == 0) ? m_o : (slot == 1) ? m_t : m_h;
    es = lit ? seg_ref[digit] : 7'h7F;
    ea = !lit ? 3'b111 : (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
    ed = ((m_n % 12) == 11);
    @(posedge clk);
    #1;
    if (ld) begin
      m_h = hh;
      m_t = tt;
      m_o = oo;
    end
    m_n++;
    chk("seg", bus.seg, es);
    chk("an", {4'd0, bus.an}, {4'd0, ea});
    chk("slot_done", {6'd0, bus.slot_done}, {6'd0, ed});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.load  = 1'b0;
    bus.h     = 4'd0;
    bus.t     = 4'd0;
    bus.o     = 4'd0;
    bus.blank = 1'b0;
    #12;
    chk("reset_seg", bus.seg, 7'h7F);
    chk("reset_an", {4'd0, bus.an}, 7'h07);
    chk("reset_slot_done", {6'd0, bus.slot_done}, 7'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_n = 0;
    m_h = 4'd0;
    m_t = 4'd0;
    m_o = 4'd0;

    idle(26);
    step(1'b1, 4'd1, 4'd2, 4'd7, 1'b0);
    idle(13);
    step(1'b1, 4'd0, 4'd0, 4'd5, 1'b0);
    idle(13);
    step(1'b1, 4'd3, 4'hC, 4'd9, 1'b0);
    idle(13);
    for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    idle(13);

    for (int i = 0; i < 150; i++) begin
      step(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
    end

    // Land in a lit ones-digit cycle, then pull reset between clock edges.
    step(1'b1, 4'd8, 4'd8, 4'd8, 1'b0);
    for (int i = 0; i < 4 && (m_n % 4) != 3; i++) idle(1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg", bus.seg, 7'h7F);
    chk("async_rst_an", {4'd0, bus.an}, 7'h07);
    chk("async_rst_slot_done", {6'd0, bus.slot_done}, 7'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_n = 0;
    m_h = 4'd0;
    m_t = 4'd0;
    m_o = 4'd0;
    idle(14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
Downstream consumer of the binary-to-BCD stage in the vending machine display path. Captures three BCD digits (hundreds, tens, ones) on a load strobe and time-multiplexes them onto a 3-digit common-anode seven-segment display. Handles the per-digit refresh timing, inter-digit dead time (anti-ghosting), and invalid-code display. Sits between the BCD converter output and the board display pins.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (≥ 2).
DEAD_CYC, 16, cycles at the start of each slot with all anodes off (1 ≤ DEAD_CYC < SCAN_DIV).
CNT_W, 16, prescaler width; must satisfy 2^CNT_W > SCAN_DIV.

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  one-cycle strobe; capture h/t/o
h  in  4  hundreds BCD digit
t  in  4  tens BCD digit
o  in  4  ones BCD digit
blank  in  1  level; 1 forces display dark
seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
an  out  3  anodes {hund,tens,ones}, active-low, registered
slot_done  out  1  one-cycle pulse on the last cycle of the HUND slot (full frame complete)

Behaviour:
- Reset (async, rst_n=0): seg=7'h7F, an=3'b111, slot_done=0, prescaler=0, state=S_ONES, digit latches h_q=t_q=o_q=0. Outputs go to these values immediately on rst_n falling, regardless of clk.
- Capture: when load=1 at a rising edge, h_q/t_q/o_q <= h/t/o. Without load, latches hold. A load mid-slot takes effect from the next cycle (the digit currently shown may change within the slot; this is acceptable).
- Prescaler: counts 0..SCAN_DIV-1, then wraps to 0 and advances the state.
- FSM: S_ONES -> S_TENS -> S_HUND -> S_ONES; the transition occurs on the edge where prescaler == SCAN_DIV-1. No other states. Illegal encodings recover to S_ONES.
- Output register (1-cycle latency from state/prescaler/latches):
  - If prescaler < DEAD_CYC, or blank=1: an=3'b111, seg=7'h7F.
  - Otherwise, drive the active-low anode of the current state (S_ONES -> 3'b110, S_TENS -> 3'b101, S_HUND -> 3'b011) and seg = encode(selected digit).
- Encoding (active-low gfedcba): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Codes 10..15 display a dash: seg=7'h3F.
- slot_done: registered, asserts for exactly one cycle, aligned with the output-register cycle of the final HUND slot cycle.
- blank has priority over everything except reset. The FSM and prescaler keep running while blank=1, so slot_done cadence is unaffected.
- Simultaneous load and slot boundary: both take effect; the new slot displays the newly captured digit.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: the hundreds digit is blanked (its anode stays off) when h_q==0. The tens digit is blanked when h_q==0 and t_q==0. The ones digit is always shown. Blanked slots still consume their full SCAN_DIV time.
- Undefined: all three digits are always shown, including leading zeros.

Decomposition:
- Shared package vm_disp_pkg:
  - typedef for the scan state enum (S_ONES, S_TENS, S_HUND).
  - Constants SEG_OFF=7'h7F, SEG_DASH=7'h3F, and AN_OFF=3'b111.
  - The 16-entry BCD-to-segment constant table.
- One natural sub-module: bcd_seg_enc, purely combinational 4-bit to 7-bit active-low encoder, instantiated once on the muxed digit.

Test Plan:
- Bench configuration: SCAN_DIV=4, DEAD_CYC=1.
- Reset then idle, no load -> ones/tens/hund slots each show seg=40 for 3 cycles after a 1-cycle dark gap; an cycles 110,101,011; slot_done pulses every 12 cycles.
- load with h=1,t=2,o=7 -> seg sequence 78 (an=110), 24 (an=101), 79 (an=011). Each digit is preceded by a dead cycle with an=111.
- load with h=0,t=0,o=5, with LEADING_ZERO_BLANK_EN defined -> only the ones slot lights (seg=12); the tens and hund slots stay an=111. With the macro undefined -> seg 12, 40, 40.
- load with t=4'hC -> tens slot seg=3F (dash); the other digits are unaffected.
- blank held high for 20 cycles mid-frame -> an=111 and seg=7F throughout; slot_done still pulses at the 12-cycle cadence; the display resumes in the correct slot phase when blank drops.
- rst_n driven low asynchronously mid-slot (between clk edges) -> an=111 and seg=7F immediately. After release, the scan restarts in S_ONES with prescaler=0 and latches=0.
